ssd_scan_controller: RTL and testbench
======================================

SSD_SCAN_CONTROLLER -- requirements
Module: ssd_scan_controller

Interface
REQ-001 Parameter NUM_DIGITS, default 4, number of multiplexed digits; legal range 2..8.
REQ-002 Parameter ON_CYCLES, default 50000, clock cycles each digit is lit; minimum 1.
REQ-003 Parameter GAP_CYCLES, default 500, all-off dead-time cycles between digits; minimum 1.
REQ-004 CLK  input  1  single clock; all state changes on its rising edge.
REQ-005 RST_N  input  1  reset, asynchronous assert, active-low.
REQ-006 ENABLE  input  1  scan enable; low forces all digits off.
REQ-007 UPD_REQ  input  1  update request; held high until UPD_ACK.
REQ-008 UPD_DATA  input  4*NUM_DIGITS  hex nibbles; bits [3:0] are digit 0, the rightmost digit.
REQ-009 UPD_DP  input  NUM_DIGITS  decimal-point bits; bit i belongs to digit i.
REQ-010 UPD_ACK  output  1  one-cycle pulse: shadow registers loaded.
REQ-011 DIGIT_NUM  output  4  nibble for the per-digit segment decoder INPUT_NUM.
REQ-012 DIGIT_DP  output  1  decimal point for the segment decoder DIGITPOINT.
REQ-013 ANODE_N  output  NUM_DIGITS  digit enables, active-low, at most one low.
REQ-014 FRAME_DONE  output  1  one-cycle pulse at the end of each complete frame.

Function
REQ-015 All outputs SHALL be registered.
REQ-016 The state machine SHALL have three states: IDLE, ON and GAP. It SHALL have a cycle counter and a digit index IDX in 0..NUM_DIGITS-1.
REQ-017 In IDLE, when ENABLE=1 is sampled, the next state SHALL be ON with IDX=0 and the counter cleared.
REQ-018 In ON, ANODE_N[IDX] SHALL be 0 and every other ANODE_N bit 1. DIGIT_NUM SHALL equal shadow nibble IDX and DIGIT_DP shadow DP bit IDX. ON SHALL last exactly ON_CYCLES cycles, then go to GAP.
REQ-019 In GAP, ANODE_N SHALL be all 1s and DIGIT_NUM/DIGIT_DP SHALL hold their values. GAP SHALL last exactly GAP_CYCLES cycles. The next state SHALL be ON with IDX+1, wrapping from NUM_DIGITS-1 to 0.
REQ-020 The frame period SHALL be NUM_DIGITS*(ON_CYCLES+GAP_CYCLES) cycles.
REQ-021 FRAME_DONE SHALL pulse high for the single cycle in which the GAP following IDX=NUM_DIGITS-1 ends.
REQ-022 The shadow registers SHALL be loaded from UPD_DATA/UPD_DP only in these cases:
  - at a frame boundary, i.e. the FRAME_DONE cycle, when UPD_REQ=1;
  - in any IDLE cycle when UPD_REQ=1.
  UPD_ACK SHALL pulse in the load cycle. A displayed frame SHALL never mix old and new data.
REQ-023 UPD_ACK SHALL NOT reassert while UPD_REQ stays high for the cycle after an ACK; a new request requires UPD_REQ low for at least one cycle.
REQ-024 ENABLE=0 sampled in ON or GAP SHALL move the block to IDLE on the next edge, with ANODE_N all 1s and IDX=0. FRAME_DONE SHALL NOT pulse for that partial frame.
REQ-025 ENABLE and UPD_REQ both asserted in the same IDLE cycle: the load and ACK SHALL occur, and ON for digit 0 SHALL start on the next edge using the new data.

Reset
REQ-026 While RST_N=0, without waiting for a clock edge, the block SHALL force:
  - state IDLE, IDX=0, counter 0;
  - shadow nibbles and DP bits 0;
  - ANODE_N all 1s, DIGIT_NUM=0, DIGIT_DP=0, UPD_ACK=0, FRAME_DONE=0.
REQ-027 Reset asserted mid-frame SHALL abandon the frame. After release, scanning SHALL resume only via IDLE->ON at digit 0.

Configuration
REQ-028 With macro SSD_LEADING_ZERO_BLANK_EN defined, leading-zero blanking SHALL apply:
  - Scanning from digit NUM_DIGITS-1 downward, each digit whose shadow nibble is 0 and DP bit is 0 SHALL be blank, up to the first non-blank digit.
  - Digit 0 SHALL never be blanked.
  - A blank digit SHALL keep ANODE_N all 1s during its ON slot.
  - Slot timing, frame period and FRAME_DONE SHALL be unchanged.
REQ-029 Without SSD_LEADING_ZERO_BLANK_EN, every digit SHALL be lit in its ON slot regardless of value, and no blanking logic SHALL be synthesised.

Verification (NUM_DIGITS=4, ON_CYCLES=4, GAP_CYCLES=2)
REQ-030 Reset release, ENABLE=1 -> ANODE_N 1110 x4, 1111 x2, 1101 x4, 1111 x2 ..., then 0111; FRAME_DONE pulses every 24 cycles.
REQ-031 UPD_REQ with UPD_DATA=16'h1234, UPD_DP=4'b0010, raised mid-frame -> UPD_ACK only in the FRAME_DONE cycle. The next frame shows DIGIT_NUM 4,3,2,1 in order, with DIGIT_DP=1 only in digit 1's slot.
REQ-032 ENABLE dropped in cycle 2 of digit 1's ON -> next cycle ANODE_N=1111 with no FRAME_DONE. Re-enabling starts at digit 0 (1110).
REQ-033 Macro defined, shadow 16'h0050, DP 4'b0000 -> ANODE_N bits 3 and 2 never low; digits 1 and 0 lit. Without the macro, all four digits lit.
REQ-034 RST_N pulled low between clock edges during ON -> ANODE_N=1111 and DIGIT_NUM=0 immediately. After release, stays IDLE until ENABLE is sampled high.
REQ-035 UPD_REQ and ENABLE raised together in IDLE with 16'hABCD -> UPD_ACK the following edge. The first ON slot shows DIGIT_NUM=4'hD.

Source files
------------

// File: rtl/ssd_scan_controller_if.sv
`default_nettype none
// ============================================================================
// Module      : ssd_scan_controller_if
// Description : Shadow-register update bus for the seven-segment scan
//               controller. The producer raises upd_req with data and
//               decimal points and holds them until upd_ack pulses.
// Revision    : 1.0 - initial release
// ============================================================================
interface ssd_scan_controller_if #(
    parameter int NUM_DIGITS = 4
) ();
    logic                      upd_req;
    logic [4*NUM_DIGITS-1:0]   upd_data;
    logic [NUM_DIGITS-1:0]     upd_dp;
    logic                      upd_ack;

    modport master (
        output upd_req,
        output upd_data,
        output upd_dp,
        input  upd_ack
    );

    modport slave (
        input  upd_req,
        input  upd_data,
        input  upd_dp,
        output upd_ack
    );
endinterface
`default_nettype wire

// File: rtl/ssd_scan_controller.sv
`default_nettype none
// ============================================================================
// Module      : ssd_scan_controller
// Description : Time-multiplexed seven-segment digit scanner. Each digit is
//               lit for ON_CYCLES then followed by GAP_CYCLES of dead time.
//               New display data is double-buffered in shadow registers and
//               only taken at a frame boundary or while idle, so a frame
//               never mixes old and new data.
//               Optional feature macro: SSD_LEADING_ZERO_BLANK_EN
//               (leading-zero blanking of the upper digits).
// Revision    : 1.0 - initial release
// ============================================================================
module ssd_scan_controller #(
    parameter int NUM_DIGITS = 4,
    parameter int ON_CYCLES  = 50000,
    parameter int GAP_CYCLES = 500
) (
    input  wire logic                  clk_i,
    input  wire logic                  rst_n_i,
    input  wire logic                  enable_i,
    ssd_scan_controller_if.slave       upd,
    output logic [3:0]                 digit_num_o,
    output logic                       digit_dp_o,
    output logic [NUM_DIGITS-1:0]      anode_n_o,
    output logic                       frame_done_o
);

    localparam int CNT_MAX = (ON_CYCLES > GAP_CYCLES) ? ON_CYCLES : GAP_CYCLES;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);
    localparam int IDX_W   = $clog2(NUM_DIGITS);

    localparam logic [CNT_W-1:0] ON_LAST  = CNT_W'(ON_CYCLES - 1);
    localparam logic [CNT_W-1:0] GAP_LAST = CNT_W'(GAP_CYCLES - 1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_DIGITS - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_ON   = 2'd1,
        S_GAP  = 2'd2
    } state_t;

    state_t                  state_q, state_d;
    logic [CNT_W-1:0]        cnt_q, cnt_d;
    logic [IDX_W-1:0]        idx_q, idx_d;
    logic [4*NUM_DIGITS-1:0] shadow_num_q, shadow_num_d;
    logic [NUM_DIGITS-1:0]   shadow_dp_q, shadow_dp_d;
    logic                    lock_q, lock_d;
    logic                    ack_q, ack_d;
    logic                    frame_done_q, frame_done_d;
    logic [NUM_DIGITS-1:0]   anode_n_q, anode_n_d;
    logic [3:0]              digit_num_q, digit_num_d;
    logic                    digit_dp_q, digit_dp_d;

    logic                    w_load;
    logic                    w_lit;

    // Scan sequencing: IDLE -> ON(idx) -> GAP -> ON(idx+1) ...; disable aborts to IDLE.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        case (state_q)
            S_IDLE: begin
                if (enable_i) begin
                    state_d = S_ON;
                    cnt_d   = '0;
                    idx_d   = '0;
                end
            end
            S_ON: begin
                if (!enable_i) begin
                    state_d = S_IDLE;
                    cnt_d   = '0;
                    idx_d   = '0;
                end else if (cnt_q == ON_LAST) begin
                    state_d = S_GAP;
                    cnt_d   = '0;
                end else begin
                    cnt_d   = cnt_q + 1'b1;
                end
            end
            S_GAP: begin
                if (!enable_i) begin
                    state_d = S_IDLE;
                    cnt_d   = '0;
                    idx_d   = '0;
                end else if (cnt_q == GAP_LAST) begin
                    state_d = S_ON;
                    cnt_d   = '0;
                    idx_d   = (idx_q == IDX_LAST) ? '0 : idx_q + 1'b1;
                end else begin
                    cnt_d   = cnt_q + 1'b1;
                end
            end
            default: begin
                state_d = S_IDLE;
                cnt_d   = '0;
                idx_d   = '0;
            end
        endcase
    end

    // Frame-end detection and shadow load; a served request stays locked until upd_req drops.
    always_comb begin
        frame_done_d = (state_d == S_GAP) && (idx_d == IDX_LAST) && (cnt_d == GAP_LAST);
        w_load       = upd.upd_req && !lock_q && ((state_q == S_IDLE) || frame_done_d);
        shadow_num_d = w_load ? upd.upd_data : shadow_num_q;
        shadow_dp_d  = w_load ? upd.upd_dp   : shadow_dp_q;
        lock_d       = w_load || (lock_q && upd.upd_req);
        ack_d        = w_load;
    end

`ifdef SSD_LEADING_ZERO_BLANK_EN
    logic [NUM_DIGITS-1:0] w_blank;
    logic                  w_run;

    // Leading digits that are zero with no decimal point stay dark; digit 0 always lights.
    always_comb begin
        w_blank = '0;
        w_run   = 1'b1;
        for (int i = NUM_DIGITS - 1; i >= 1; i--) begin
            w_run      = w_run && (shadow_num_d[4*i +: 4] == 4'h0) && !shadow_dp_d[i];
            w_blank[i] = w_run;
        end
    end

    assign w_lit = !w_blank[idx_d];
`else
    assign w_lit = 1'b1;
`endif

    // Output values for the upcoming cycle; digit data holds outside ON so the decoder is stable.
    always_comb begin
        anode_n_d   = '1;
        digit_num_d = digit_num_q;
        digit_dp_d  = digit_dp_q;
        if (state_d == S_ON) begin
            digit_num_d = shadow_num_d[{idx_d, 2'b00} +: 4];
            digit_dp_d  = shadow_dp_d[idx_d];
            if (w_lit) begin
                anode_n_d[idx_d] = 1'b0;
            end
        end
    end

    // State and output registers with asynchronous active-low reset.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q      <= S_IDLE;
            cnt_q        <= '0;
            idx_q        <= '0;
            shadow_num_q <= '0;
            shadow_dp_q  <= '0;
            lock_q       <= 1'b0;
            ack_q        <= 1'b0;
            frame_done_q <= 1'b0;
            anode_n_q    <= '1;
            digit_num_q  <= 4'h0;
            digit_dp_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            idx_q        <= idx_d;
            shadow_num_q <= shadow_num_d;
            shadow_dp_q  <= shadow_dp_d;
            lock_q       <= lock_d;
            ack_q        <= ack_d;
            frame_done_q <= frame_done_d;
            anode_n_q    <= anode_n_d;
            digit_num_q  <= digit_num_d;
            digit_dp_q   <= digit_dp_d;
        end
    end

    assign upd.upd_ack   = ack_q;
    assign frame_done_o  = frame_done_q;
    assign anode_n_o     = anode_n_q;
    assign digit_num_o   = digit_num_q;
    assign digit_dp_o    = digit_dp_q;

endmodule
`default_nettype wire

// File: tb/tb_ssd_scan_controller.sv
`default_nettype none
// ============================================================================
// Module      : tb_ssd_scan_controller
// Description : Scoreboard bench for ssd_scan_controller (4 digits, ON=4,
//               GAP=2). Stimulus pushes expected lit cycles, ACK cycles and
//               FRAME_DONE cycles into queues; a monitor pops on each event.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_ssd_scan_controller;

    localparam int ND  = 4;
    localparam int ONC = 4;
    localparam int GPC = 2;

`ifdef SSD_LEADING_ZERO_BLANK_EN
    localparam logic [3:0] BLANK_ZERO = 4'b1110;
    localparam logic [3:0] BLANK_0050 = 4'b1100;
`else
    localparam logic [3:0] BLANK_ZERO = 4'b0000;
    localparam logic [3:0] BLANK_0050 = 4'b0000;
`endif

    typedef struct {
        int         cyc;
        logic [3:0] an;
        logic [3:0] num;
        logic       dp;
    } lit_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        enable = 1'b0;
    logic [3:0]  digit_num;
    logic        digit_dp;
    logic [3:0]  anode_n;
    logic        frame_done;

    int cyc    = 0;
    int checks = 0;
    int errors = 0;

    lit_t lit_q[$];
    int   ack_q[$];
    int   fd_q[$];

    ssd_scan_controller_if #(.NUM_DIGITS(ND)) u_if ();

    ssd_scan_controller #(
        .NUM_DIGITS (ND),
        .ON_CYCLES  (ONC),
        .GAP_CYCLES (GPC)
    ) u_dut (
        .clk_i        (clk),
        .rst_n_i      (rst_n),
        .enable_i     (enable),
        .upd          (u_if),
        .digit_num_o  (digit_num),
        .digit_dp_o   (digit_dp),
        .anode_n_o    (anode_n),
        .frame_done_o (frame_done)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_until(input int c);
        while (cyc < c) tick();
    endtask

    // Expected lit cycles of a frame whose ENABLE was first sampled at edge base+1.
    task automatic push_frame(input int base, input logic [15:0] data, input logic [3:0] dp,
                              input int upto, input logic [3:0] blank);
        for (int d = 0; d < ND; d++) begin
            for (int c = 0; c < ONC; c++) begin
                int off;
                off = d * (ONC + GPC) + c + 1;
                if (off <= upto && !blank[d]) begin
                    lit_t e;
                    e.cyc   = base + off;
                    e.an    = 4'hF;
                    e.an[d] = 1'b0;
                    e.num   = data[4*d +: 4];
                    e.dp    = dp[d];
                    lit_q.push_back(e);
                end
            end
        end
        if (upto >= ND * (ONC + GPC)) fd_q.push_back(base + ND * (ONC + GPC));
    endtask

    // Monitor: every lit digit, ACK pulse and FRAME_DONE pulse must match the next queued entry.
    always @(negedge clk) begin
        if (anode_n != 4'hF) begin
            if (lit_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL lit_unexpected cycle=%0d anode=%b required=no_lit", cyc, anode_n);
            end else begin
                lit_t e;
                e = lit_q.pop_front();
                check("lit_cyc_anode_num_dp",
                      {23'd0, cyc, anode_n, digit_num, digit_dp},
                      {23'd0, e.cyc, e.an, e.num, e.dp});
            end
        end
        if (u_if.upd_ack) begin
            if (ack_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL ack_unexpected cycle=%0d required=no_ack", cyc);
            end else begin
                check("ack_cycle", 64'(cyc), 64'(ack_q.pop_front()));
            end
        end
        if (frame_done) begin
            if (fd_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL frame_done_unexpected cycle=%0d required=no_pulse", cyc);
            end else begin
                check("frame_done_cycle", 64'(cyc), 64'(fd_q.pop_front()));
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog cycle=%0d required=finish", cyc);
        $fatal(1, "timeout");
    end

    initial begin
        int b1, b2, b3, m, b4, b5;
        u_if.upd_req  = 1'b0;
        u_if.upd_data = 16'h0;
        u_if.upd_dp   = 4'h0;

        // Asynchronous reset before any clock edge.
        #1 rst_n = 1'b0;
        #1;
        check("reset_anode", 64'(anode_n), 64'hF);
        check("reset_num", 64'(digit_num), 64'h0);
        check("reset_dp", 64'(digit_dp), 64'h0);
        check("reset_ack", 64'(u_if.upd_ack), 64'h0);
        check("reset_frame_done", 64'(frame_done), 64'h0);
        tick(); tick(); tick();
        rst_n = 1'b1;
        tick(); tick();

        // Free-running scan, mid-frame update taken at the frame boundary, then abort in digit 1.
        b1 = cyc;
        enable = 1'b1;
        push_frame(b1, 16'h0000, 4'b0000, 24, BLANK_ZERO);
        push_frame(b1 + 24, 16'h1234, 4'b0010, 24, 4'b0000);
        push_frame(b1 + 48, 16'h1234, 4'b0010, 8, 4'b0000);
        ack_q.push_back(b1 + 24);
        wait_until(b1 + 5);
        u_if.upd_req  = 1'b1;
        u_if.upd_data = 16'h1234;
        u_if.upd_dp   = 4'b0010;
        wait_until(b1 + 26);
        u_if.upd_req  = 1'b0;
        wait_until(b1 + 56);
        enable = 1'b0;

        // Re-enable restarts at digit 0; stop right after a complete frame.
        wait_until(b1 + 62);
        b2 = cyc;
        enable = 1'b1;
        push_frame(b2, 16'h1234, 4'b0010, 24, 4'b0000);
        wait_until(b2 + 24);
        enable = 1'b0;

        // Reset between clock edges during an ON slot.
        wait_until(b2 + 28);
        b3 = cyc;
        enable = 1'b1;
        push_frame(b3, 16'h1234, 4'b0010, 2, 4'b0000);
        wait_until(b3 + 2);
        @(negedge clk);
        #2;
        rst_n  = 1'b0;
        enable = 1'b0;
        #1;
        check("midframe_reset_anode", 64'(anode_n), 64'hF);
        check("midframe_reset_num", 64'(digit_num), 64'h0);
        check("midframe_reset_dp", 64'(digit_dp), 64'h0);
        tick(); tick();
        rst_n = 1'b1;
        wait_until(b3 + 10);

        // Idle load with request held past ACK (single ACK), then blanking pattern 0050.
        m = cyc;
        u_if.upd_req  = 1'b1;
        u_if.upd_data = 16'h0050;
        u_if.upd_dp   = 4'b0000;
        ack_q.push_back(m + 1);
        wait_until(m + 4);
        u_if.upd_req = 1'b0;
        wait_until(m + 6);
        b4 = cyc;
        enable = 1'b1;
        push_frame(b4, 16'h0050, 4'b0000, 24, BLANK_0050);
        wait_until(b4 + 24);
        enable = 1'b0;

        // Request and enable together in IDLE: first ON slot already shows the new data.
        wait_until(b4 + 28);
        b5 = cyc;
        u_if.upd_req  = 1'b1;
        u_if.upd_data = 16'hABCD;
        u_if.upd_dp   = 4'b0000;
        enable        = 1'b1;
        ack_q.push_back(b5 + 1);
        push_frame(b5, 16'hABCD, 4'b0000, 24, 4'b0000);
        wait_until(b5 + 3);
        u_if.upd_req = 1'b0;
        wait_until(b5 + 24);
        enable = 1'b0;
        wait_until(b5 + 32);

        check("lit_queue_drained", 64'(lit_q.size()), 64'h0);
        check("ack_queue_drained", 64'(ack_q.size()), 64'h0);
        check("frame_done_queue_drained", 64'(fd_q.size()), 64'h0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
